// File: rtl/helper_axis_pkg.sv
// Shared types and constants for the AXI-Stream comparator helper.
package helper_axis_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DONE = 2'd1,
    HALT = 2'd2
  } cmp_state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/helper_lfsr16.sv
// 16-bit Fibonacci LFSR used to throttle the comparator's ready.
module helper_lfsr16
  import helper_axis_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] lfsr_r;

  // Shift register: reload seed on reset, advance only while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= seed;
    end else if (enable) begin
      lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
    end
  end

  assign state = lfsr_r;

endmodule

// File: rtl/helper_axis_comparator.sv
// Compares a stream under test against a reference stream beat by beat,
// keeping transfer/mismatch counts and a capture of the first mismatch.
module helper_axis_comparator
  import helper_axis_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 10,
  parameter int                    COUNT_WIDTH    = 32,
  parameter int                    EXPECTED_COUNT = 0,
  parameter int                    STOP_ON_ERROR  = 0,
  parameter int                    READY_MODE     = 0,
  parameter logic [15:0]           LFSR_SEED      = LFSR_DEFAULT_SEED,
  parameter logic [DATA_WIDTH-1:0] COMPARE_MASK   = {DATA_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   input_valid,
  input  logic [DATA_WIDTH-1:0]  input_data,
  input  logic                   input_last,
  output logic                   input_ready,
  input  logic                   ref_valid,
  input  logic [DATA_WIDTH-1:0]  ref_data,
  input  logic                   ref_last,
  output logic                   ref_ready,
  output logic                   error,
  output logic                   done,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] transfer_count,
  output logic [COUNT_WIDTH-1:0] mismatch_count,
  output logic [COUNT_WIDTH-1:0] first_err_index,
  output logic [DATA_WIDTH-1:0]  first_err_data,
  output logic [DATA_WIDTH-1:0]  first_err_expected
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] EXP_CNT     = COUNT_WIDTH'(EXPECTED_COUNT);
  localparam logic                   STOP_EN     = (STOP_ON_ERROR != 0);
  localparam logic                   THROTTLE_EN = (READY_MODE != 0);
  localparam logic                   COUNT_EN    = (EXPECTED_COUNT != 0);

  cmp_state_e              state_r;
  cmp_state_e              next_state_s;
  logic [15:0]             lfsr_s;
  logic                    unused_lfsr_s;
  logic                    accept_s;
  logic                    xfer_s;
  logic                    mismatch_s;
  logic [COUNT_WIDTH-1:0]  transfer_count_r;
  logic [COUNT_WIDTH-1:0]  mismatch_count_r;
  logic [COUNT_WIDTH-1:0]  tc_inc_s;
  logic [COUNT_WIDTH-1:0]  mc_inc_s;
  logic [COUNT_WIDTH-1:0]  first_err_index_r;
  logic [DATA_WIDTH-1:0]   first_err_data_r;
  logic [DATA_WIDTH-1:0]   first_err_expected_r;
  logic                    error_r;
  logic                    done_r;
  logic                    halted_r;

  helper_lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .seed   (LFSR_SEED),
    .state  (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s[15:1];

  // Readies are suppressed during reset so no beat is consumed in that cycle.
  assign accept_s    = ~rst & enable & (state_r == RUN) & (~THROTTLE_EN | lfsr_s[0]);
  assign input_ready = accept_s & ref_valid;
  assign ref_ready   = accept_s & input_valid;
  assign xfer_s      = accept_s & input_valid & ref_valid;
  assign mismatch_s  = xfer_s & ((|((input_data ^ ref_data) & COMPARE_MASK)) | (input_last ^ ref_last));

  assign tc_inc_s = (transfer_count_r == CNT_MAX) ? transfer_count_r : transfer_count_r + CNT_ONE;
  assign mc_inc_s = (mismatch_count_r == CNT_MAX) ? mismatch_count_r : mismatch_count_r + CNT_ONE;

  // Next-state logic; HALT wins over DONE when both fire on one beat.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RUN: begin
        if (mismatch_s && STOP_EN) begin
          next_state_s = HALT;
        end else if (xfer_s && COUNT_EN && (tc_inc_s == EXP_CNT)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = DONE;
      HALT:    next_state_s = HALT;
      default: next_state_s = RUN;
    endcase
  end

  // State register and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= RUN;
      done_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      done_r   <= (next_state_s == DONE);
      halted_r <= (next_state_s == HALT);
    end
  end

  // Counters, sticky error and first-mismatch capture (error_r gates the capture).
  always_ff @(posedge clk) begin
    if (rst) begin
      transfer_count_r     <= {COUNT_WIDTH{1'b0}};
      mismatch_count_r     <= {COUNT_WIDTH{1'b0}};
      first_err_index_r    <= {COUNT_WIDTH{1'b0}};
      first_err_data_r     <= {DATA_WIDTH{1'b0}};
      first_err_expected_r <= {DATA_WIDTH{1'b0}};
      error_r              <= 1'b0;
    end else begin
      if (xfer_s) begin
        transfer_count_r <= tc_inc_s;
      end
      if (mismatch_s) begin
        mismatch_count_r <= mc_inc_s;
        error_r          <= 1'b1;
        if (!error_r) begin
          first_err_index_r    <= transfer_count_r;
          first_err_data_r     <= input_data;
          first_err_expected_r <= ref_data;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Simulation report of every mismatching beat.
  always_ff @(posedge clk) begin
    if (mismatch_s) begin
      $info("helper_axis_comparator: index %0d received %0h expected %0h",
            transfer_count_r, input_data, ref_data);
    end
  end
`endif

  assign error              = error_r;
  assign done               = done_r;
  assign halted             = halted_r;
  assign transfer_count     = transfer_count_r;
  assign mismatch_count     = mismatch_count_r;
  assign first_err_index    = first_err_index_r;
  assign first_err_data     = first_err_data_r;
  assign first_err_expected = first_err_expected_r;

endmodule

// File: tb/tb_helper_axis_comparator.sv
// Self-checking bench: four comparator configurations share one stimulus,
// each tracked by a behavioural model, plus literal end-of-scenario checks.
module tb_helper_axis_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       iv = 1'b0, rv = 1'b0, il = 1'b0, rl = 1'b0;
  logic [9:0] id = 10'd0, rd = 10'd0;

  logic [3:0]        ir_w, rr_w, err_w, done_w, halt_w;
  logic [3:0][31:0]  tc_w, mc_w, fi_w;
  logic [3:0][9:0]   fd_w, fe_w;

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // stimulus tables
  logic [9:0] s_id[16], s_rd[16];
  logic       s_il[16], s_rl[16];
  int         s_n;

  // model state, one slot per instance (0 plain, 1 masked, 2 stop, 3 throttled)
  int          m_state[4];
  logic [15:0] m_lfsr[4];
  logic [31:0] m_tc[4], m_mc[4], m_fi[4];
  logic [9:0]  m_fd[4], m_fe[4];
  logic        m_err[4];

  always #5 clk = ~clk;

  helper_axis_comparator #(.EXPECTED_COUNT(8)) u_plain (
    .clk(clk), .rst(rst), .enable(enable),
    .input_valid(iv), .input_data(id), .input_last(il), .input_ready(ir_w[0]),
    .ref_valid(rv), .ref_data(rd), .ref_last(rl), .ref_ready(rr_w[0]),
    .error(err_w[0]), .done(done_w[0]), .halted(halt_w[0]),
    .transfer_count(tc_w[0]), .mismatch_count(mc_w[0]),
    .first_err_index(fi_w[0]), .first_err_data(fd_w[0]), .first_err_expected(fe_w[0]));

  helper_axis_comparator #(.EXPECTED_COUNT(8), .COMPARE_MASK(10'h3F0)) u_mask (
    .clk(clk), .rst(rst), .enable(enable),
    .input_valid(iv), .input_data(id), .input_last(il), .input_ready(ir_w[1]),
    .ref_valid(rv), .ref_data(rd), .ref_last(rl), .ref_ready(rr_w[1]),
    .error(err_w[1]), .done(done_w[1]), .halted(halt_w[1]),
    .transfer_count(tc_w[1]), .mismatch_count(mc_w[1]),
    .first_err_index(fi_w[1]), .first_err_data(fd_w[1]), .first_err_expected(fe_w[1]));

  helper_axis_comparator #(.EXPECTED_COUNT(8), .STOP_ON_ERROR(1)) u_stop (
    .clk(clk), .rst(rst), .enable(enable),
    .input_valid(iv), .input_data(id), .input_last(il), .input_ready(ir_w[2]),
    .ref_valid(rv), .ref_data(rd), .ref_last(rl), .ref_ready(rr_w[2]),
    .error(err_w[2]), .done(done_w[2]), .halted(halt_w[2]),
    .transfer_count(tc_w[2]), .mismatch_count(mc_w[2]),
    .first_err_index(fi_w[2]), .first_err_data(fd_w[2]), .first_err_expected(fe_w[2]));

  helper_axis_comparator #(.EXPECTED_COUNT(8), .READY_MODE(1), .LFSR_SEED(16'hACE1)) u_thr (
    .clk(clk), .rst(rst), .enable(enable),
    .input_valid(iv), .input_data(id), .input_last(il), .input_ready(ir_w[3]),
    .ref_valid(rv), .ref_data(rd), .ref_last(rl), .ref_ready(rr_w[3]),
    .error(err_w[3]), .done(done_w[3]), .halted(halt_w[3]),
    .transfer_count(tc_w[3]), .mismatch_count(mc_w[3]),
    .first_err_index(fi_w[3]), .first_err_data(fd_w[3]), .first_err_expected(fe_w[3]));

  function automatic logic [9:0] cfg_mask(input int k);
    return (k == 1) ? 10'h3F0 : 10'h3FF;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Behavioural model: apply the comparator rules to the beat seen at this edge.
  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_state[k] = 0;
        m_lfsr[k]  = 16'hACE1;
        m_tc[k] = 32'd0; m_mc[k] = 32'd0; m_fi[k] = 32'd0;
        m_fd[k] = 10'd0; m_fe[k] = 10'd0; m_err[k] = 1'b0;
      end else if (enable) begin
        bit acc, mm;
        acc = (m_state[k] == 0) && (k != 3 || m_lfsr[k][0]);
        if (acc && iv && rv) begin
          mm = (((id ^ rd) & cfg_mask(k)) != 10'd0) || (il != rl);
          if (mm) begin
            if (!m_err[k]) begin
              m_fi[k] = m_tc[k];
              m_fd[k] = id;
              m_fe[k] = rd;
            end
            m_err[k] = 1'b1;
            if (m_mc[k] != 32'hFFFF_FFFF) m_mc[k] = m_mc[k] + 32'd1;
          end
          if (m_tc[k] != 32'hFFFF_FFFF) m_tc[k] = m_tc[k] + 32'd1;
          if (mm && k == 2) m_state[k] = 2;
          else if (m_tc[k] == 32'd8) m_state[k] = 1;
        end
        m_lfsr[k] = {m_lfsr[k][14:0],
                     m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int k = 0; k < 4; k++) begin
          bit acc;
          acc = !rst && enable && (m_state[k] == 0) && (k != 3 || m_lfsr[k][0]);
          chk("input_ready", k, 32'(ir_w[k]), 32'(acc && rv));
          chk("ref_ready",   k, 32'(rr_w[k]), 32'(acc && iv));
          chk("done",        k, 32'(done_w[k]), 32'(m_state[k] == 1));
          chk("halted",      k, 32'(halt_w[k]), 32'(m_state[k] == 2));
          chk("error",       k, 32'(err_w[k]), 32'(m_err[k]));
          chk("transfer_count", k, tc_w[k], m_tc[k]);
          chk("mismatch_count", k, mc_w[k], m_mc[k]);
          chk("first_err_index", k, fi_w[k], m_fi[k]);
          chk("first_err_data", k, 32'(fd_w[k]), 32'(m_fd[k]));
          chk("first_err_expected", k, 32'(fe_w[k]), 32'(m_fe[k]));
        end
      end
    end
  end

  task automatic reset_all();
    iv = 1'b0; rv = 1'b0; enable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    checking = 1'b1;
  endtask

  task automatic load_identical();
    s_n = 8;
    for (int i = 0; i < 16; i++) begin
      s_id[i] = 10'(i); s_rd[i] = 10'(i);
      s_il[i] = (i == 7); s_rl[i] = (i == 7);
    end
  endtask

  // Drive the tables, advancing whenever the selected instance takes a beat.
  task automatic run_stream(input int sel, input int gap_at, input bit pin_first, input bit must_finish);
    int idx = 0;
    int cyc = 0;
    bit go;
    bit gapped = 1'b0;
    while (idx < s_n && cyc < 200) begin
      if (!gapped && idx == gap_at) begin
        gapped = 1'b1;
        enable = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("frozen_tc", sel, tc_w[sel], 32'(gap_at));
          @(posedge clk); #1;
        end
        enable = 1'b1;
      end
      iv = 1'b1; rv = 1'b1;
      id = s_id[idx]; rd = s_rd[idx]; il = s_il[idx]; rl = s_rl[idx];
      @(negedge clk);
      go = ir_w[sel];
      if (pin_first && cyc == 0) chk("first_ready", sel, 32'(ir_w[sel]), 32'd1);
      @(posedge clk); #1;
      if (go) idx++;
      cyc++;
    end
    if (must_finish && idx < s_n) chk("stream_budget", sel, 32'(idx), 32'(s_n));
  endtask

  task automatic idle(input int n);
    iv = 1'b0; rv = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  initial begin
    // identical streams
    reset_all();
    load_identical();
    run_stream(0, 99, 1'b0, 1'b1);
    idle(2);
    chk("s1_done", 0, 32'(done_w[0]), 32'd1);
    chk("s1_tc", 0, tc_w[0], 32'd8);
    chk("s1_mc", 0, mc_w[0], 32'd0);
    chk("s1_err", 0, 32'(err_w[0]), 32'd0);

    // single corruption at index 3
    reset_all();
    load_identical();
    s_id[3] = 10'd5;
    run_stream(0, 99, 1'b0, 1'b1);
    idle(2);
    chk("s2_err", 0, 32'(err_w[0]), 32'd1);
    chk("s2_mc", 0, mc_w[0], 32'd1);
    chk("s2_fi", 0, fi_w[0], 32'd3);
    chk("s2_fd", 0, 32'(fd_w[0]), 32'd5);
    chk("s2_fe", 0, 32'(fe_w[0]), 32'd3);

    // difference only in bit 0, masked off
    reset_all();
    load_identical();
    for (int i = 0; i < 8; i++) begin
      s_rd[i] = 10'(i * 16);
      s_id[i] = 10'(i * 16 + 1);
    end
    run_stream(1, 99, 1'b0, 1'b1);
    idle(2);
    chk("s3_mc", 1, mc_w[1], 32'd0);
    chk("s3_err", 1, 32'(err_w[1]), 32'd0);
    chk("s3_done", 1, 32'(done_w[1]), 32'd1);

    // stop on error, corruptions at 2 and 5
    reset_all();
    load_identical();
    s_id[2] = 10'd102;
    s_id[5] = 10'd105;
    run_stream(2, 99, 1'b0, 1'b0);
    @(negedge clk);
    chk("s4_ir", 2, 32'(ir_w[2]), 32'd0);
    chk("s4_rr", 2, 32'(rr_w[2]), 32'd0);
    idle(2);
    chk("s4_halted", 2, 32'(halt_w[2]), 32'd1);
    chk("s4_tc", 2, tc_w[2], 32'd3);
    chk("s4_mc", 2, mc_w[2], 32'd1);
    chk("s4_fi", 2, fi_w[2], 32'd2);

    // throttled ready with an enable gap; results match the unthrottled run
    reset_all();
    load_identical();
    run_stream(3, 4, 1'b1, 1'b1);
    idle(2);
    chk("s5_done", 3, 32'(done_w[3]), 32'd1);
    chk("s5_tc", 3, tc_w[3], 32'd8);
    chk("s5_mc", 3, mc_w[3], 32'd0);
    chk("s5_err", 3, 32'(err_w[3]), 32'd0);

    // last mismatch on equal data, then reset mid-stream
    reset_all();
    load_identical();
    s_n = 5;
    s_il[2] = 1'b1;
    run_stream(0, 99, 1'b0, 1'b1);
    @(negedge clk);
    chk("s6_mc", 0, mc_w[0], 32'd1);
    chk("s6_fi", 0, fi_w[0], 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("s6_rst_ready", 0, 32'(ir_w[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    iv = 1'b0; rv = 1'b0;
    @(negedge clk);
    chk("s6_tc", 0, tc_w[0], 32'd0);
    chk("s6_mc0", 0, mc_w[0], 32'd0);
    chk("s6_err", 0, 32'(err_w[0]), 32'd0);
    chk("s6_fd", 0, 32'(fd_w[0]), 32'd0);
    chk("s6_fi0", 0, fi_w[0], 32'd0);
    chk("s6_done", 0, 32'(done_w[0]), 32'd0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
